// File: rtl/mult_sequencer_pkg.sv
// Shared definitions for the MULT sequencer: FSM state encoding, MULT funct code, default width.
package mult_sequencer_pkg;

  localparam int unsigned WIDTH_DEF  = 32;
  localparam logic [5:0]  FUNCT_MULT = 6'b011000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// Handshake between the decoded MULT instruction (core side) and the multiply sequencer.
interface mult_sequencer_if
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             mult_req;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             instr_stall;
  logic             busy;
  logic             hi_lo_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mult_req, op_a, op_b,
    input  instr_stall, busy, hi_lo_valid, hi, lo
  );

  modport slave (
    input  mult_req, op_a, op_b,
    output instr_stall, busy, hi_lo_valid, hi, lo
  );

endinterface

// File: rtl/mult_sequencer_shift_add.sv
// Shift-add datapath: magnitude operands, 2*WIDTH accumulator, and the signed HI/LO result registers.
module mult_sequencer_shift_add
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] product_s;
  logic [WIDTH-1:0]   mplier_r;
  logic               sign_r;

  // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exactly right as an unsigned magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = ~v + WIDTH'(1);
    end else begin
      magnitude = v;
    end
  endfunction

  // Next accumulator value and signed product; finish coincides with the last step
  always_comb begin
    acc_next_s = acc_r;
    product_s  = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
    if (sign_r) begin
      product_s = ~acc_next_s + (2*WIDTH)'(1);
    end else begin
      product_s = acc_next_s;
    end
  end

  // Operand latch, per-cycle shift-add, and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_r  <= '0;
      acc_r    <= '0;
      mplier_r <= '0;
      sign_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else if (load) begin
      mcand_r  <= {WIDTH'(0), magnitude(op_a)};
      mplier_r <= magnitude(op_b);
      acc_r    <= '0;
      sign_r   <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
    end else if (step) begin
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      if (finish) begin
        hi <= product_s[2*WIDTH-1:WIDTH];
        lo <= product_s[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// MULT controller: stalls fetch while a WIDTH-cycle shift-add runs, then loads HI/LO with a valid pulse.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mult_sequencer_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t        state_r;
  logic [CW-1:0] count_r;
  logic          busy_r;
  logic          valid_r;
  logic          load_s;
  logic          step_s;
  logic          finish_s;
  logic          last_s;

  // Datapath strobes; a dropped request in RUN stops stepping so HI/LO are never written
  always_comb begin
    load_s   = 1'b0;
    step_s   = 1'b0;
    finish_s = 1'b0;
    last_s   = (count_r == CW'(WIDTH - 1));
    case (state_r)
      ST_IDLE: load_s = bus.mult_req;
      ST_RUN: begin
        step_s   = bus.mult_req;
        finish_s = bus.mult_req & last_s;
      end
      default: begin
        load_s   = 1'b0;
        step_s   = 1'b0;
        finish_s = 1'b0;
      end
    endcase
  end

  // Sequencer state, bit counter, and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      count_r <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          valid_r <= 1'b0;
          count_r <= '0;
          if (bus.mult_req) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!bus.mult_req) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            count_r <= '0;
          end else if (last_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            valid_r <= 1'b1;
            count_r <= '0;
          end else begin
            count_r <= count_r + CW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= '0;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_stall = bus.mult_req & (state_r != ST_DONE) & ~reset;
  assign bus.busy        = busy_r;
  assign bus.hi_lo_valid = valid_r;

  mult_sequencer_shift_add #(.WIDTH(WIDTH)) u_shift_add (
    .clk    (clk),
    .reset  (reset),
    .load   (load_s),
    .step   (step_s),
    .finish (finish_s),
    .op_a   (bus.op_a),
    .op_b   (bus.op_b),
    .hi     (bus.hi),
    .lo     (bus.lo)
  );

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: signed products, cycle-exact stall/valid timing, flush and async reset.
module tb_mult_sequencer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   last_valid_cyc;
  int   first_valid_cyc;

  mult_sequencer_if #(.WIDTH(32)) bus ();

  mult_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Request issued at cycle 0 (IDLE); stall high 0..32, busy 1..32, valid and new HI/LO at 33.
  // Operands are scrambled mid-RUN to show they were latched at the start.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input bit keep_req, input string tag);
    bus.mult_req = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      check({tag, " stall"}, 64'(bus.instr_stall), 64'(c <= 32));
      check({tag, " busy"},  64'(bus.busy),        64'(c >= 1 && c <= 32));
      check({tag, " valid"}, 64'(bus.hi_lo_valid), 64'(c == 33));
      if (bus.hi_lo_valid) last_valid_cyc = cyc;
      if (c == 33) begin
        check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, " lo"}, 64'(bus.lo), 64'(elo));
      end
      if (c == 5) begin
        bus.op_a = ~a;
        bus.op_b = 32'h0000_1234;
      end
      next_cycle();
    end
    bus.mult_req = keep_req;
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    cyc            = 0;
    last_valid_cyc = 0;
    reset          = 1'b1;
    bus.mult_req   = 1'b1;
    bus.op_a       = 32'd3;
    bus.op_b       = 32'd5;

    // Reset state: stall forced low even though a request is present
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst stall", 64'(bus.instr_stall), 64'd0);
    check("rst busy",  64'(bus.busy),        64'd0);
    check("rst valid", 64'(bus.hi_lo_valid), 64'd0);
    check("rst hi",    64'(bus.hi),          64'd0);
    check("rst lo",    64'(bus.lo),          64'd0);
    bus.mult_req = 1'b0;
    reset        = 1'b0;
    next_cycle();
    next_cycle();

    do_mult(32'd3,          32'd5,          32'h0000_0000, 32'h0000_000F, 1'b0, "3x5");
    next_cycle();
    do_mult(32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, "-7x6");
    do_mult(32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0, "minxmin");
    do_mult(32'h0000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0000, 1'b0, "0x-1");
    do_mult(32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, 1'b0, "-1x-1");

    // Back-to-back: second request is already present in the cycle after DONE
    do_mult(32'd2, 32'd3, 32'h0, 32'd6, 1'b1, "b2b1");
    first_valid_cyc = last_valid_cyc;
    do_mult(32'd4, 32'd5, 32'h0, 32'd20, 1'b0, "b2b2");
    // Valid pulses land on cycles 33 and 67 of the pair (34 edges apart)
    check("b2b gap", 64'(last_valid_cyc - first_valid_cyc), 64'd34);

    // Async reset in RUN cycle 10
    bus.mult_req = 1'b1;
    bus.op_a     = 32'd3;
    bus.op_b     = 32'd5;
    repeat (10) next_cycle();
    reset = 1'b1;
    #1;
    check("arst stall", 64'(bus.instr_stall), 64'd0);
    check("arst busy",  64'(bus.busy),        64'd0);
    check("arst hi",    64'(bus.hi),          64'd0);
    check("arst lo",    64'(bus.lo),          64'd0);
    bus.mult_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    next_cycle();

    // Prior HI/LO = (1,2): 6 * 0x2AAAAAAB = 0x1_0000_0002
    do_mult(32'd6, 32'h2AAA_AAAB, 32'h0000_0001, 32'h0000_0002, 1'b0, "hilo12");

    // Flush: request dropped during RUN cycle 5
    bus.mult_req = 1'b1;
    bus.op_a     = 32'd3;
    bus.op_b     = 32'd5;
    repeat (5) next_cycle();
    @(negedge clk);
    check("flush busy5", 64'(bus.busy), 64'd1);
    bus.mult_req = 1'b0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      @(negedge clk);
      check("flush valid", 64'(bus.hi_lo_valid), 64'd0);
      check("flush busy",  64'(bus.busy),        64'd0);
    end
    check("flush stall", 64'(bus.instr_stall), 64'd0);
    check("flush hi",    64'(bus.hi),          64'd1);
    check("flush lo",    64'(bus.lo),          64'd2);
    next_cycle();

    // Sequencer is back in IDLE and fully usable after the flush
    do_mult(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, "7x-2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
